// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / fixed-select channel mux.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Bits needed to index n items, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins,
// searching upward and wrapping modulo N_CH.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    localparam logic [SEL_W:0] NCH_W = (SEL_W+1)'(N_CH);

    logic [N_CH-1:0]  rot;
    logic             found;
    logic [SEL_W-1:0] off;
    logic [SEL_W:0]   sum;

    always_comb begin
        // Rotating the doubled request vector puts channel ptr at bit 0.
        rot   = N_CH'({req, req} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = j[SEL_W-1:0];
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NCH_W) sum = sum - NCH_W;
        gnt_idx = sum[SEL_W-1:0];
        gnt     = '0;
        for (int i = 0; i < N_CH; i++) begin
            gnt[i] = en && found && (sum == (SEL_W+1)'(i));
        end
    end

endmodule

// File: rtl/mux_rr_select.sv
// N_CH-to-1 valid/ready mux with fixed-select or round-robin channel choice and
// a single registered output stage that refills in the cycle it drains.
module mux_rr_select
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 8,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    // Handshake: a beat moves on any interface only in a cycle where its valid
    // and ready are both high; valid never waits on ready, and in_ready is a
    // combinational function of output occupancy, mode, sel and the RR grant.

    localparam logic [SEL_W:0] NCH_W = (SEL_W+1)'(N_CH);

    logic             load_en;
    logic             rr_en;
    logic             sel_ok;
    logic             xfer;
    logic [N_CH-1:0]  rr_gnt;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W:0]   ptr_inc;
    logic [SEL_W-1:0] xfer_ch;
    logic [W-1:0]     xfer_data;

    assign load_en = !out_valid || out_ready;
    assign rr_en   = (mode == MODE_RR);
    assign sel_ok  = ({1'b0, sel} < NCH_W);

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .en      (rr_en),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    always_comb begin
        in_ready  = '0;
        xfer      = 1'b0;
        xfer_ch   = '0;
        xfer_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rr_en) begin
                in_ready[i] = !rst && load_en && rr_gnt[i];
            end else begin
                in_ready[i] = !rst && load_en && sel_ok && (sel == i[SEL_W-1:0]);
            end
            if (in_valid[i] && in_ready[i]) begin
                xfer      = 1'b1;
                xfer_ch   = i[SEL_W-1:0];
                xfer_data = in_data[i*W +: W];
            end
        end
    end

    // Explicit wrap keeps the pointer legal when N_CH is not a power of two.
    assign ptr_inc = {1'b0, rr_idx} + (SEL_W+1)'(1);
    assign ptr_nxt = (ptr_inc >= NCH_W) ? '0 : ptr_inc[SEL_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= xfer_data;
                    out_ch   <= xfer_ch;
                end
            end
            if (xfer && rr_en) ptr <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_mux_rr_select.sv
// Bench for mux_rr_select: a 4-channel and a 3-channel instance run side by side
// against a behavioural model of the selection rules.
module tb_mux_rr_select;

  logic clk;
  logic rst;

  logic [7:0] v_data[2][4];
  logic [3:0] v_valid[2];
  logic [1:0] v_sel[2];
  logic       v_mode[2];
  logic       v_ordy[2];

  logic [31:0] in_data4;
  logic [3:0]  in_ready4;
  logic [7:0]  out_data4;
  logic [1:0]  out_ch4;
  logic        out_valid4;

  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;

  assign in_data4 = {v_data[0][3], v_data[0][2], v_data[0][1], v_data[0][0]};
  assign in_data3 = {v_data[1][2], v_data[1][1], v_data[1][0]};

  mux_rr_select #(.N_CH(4), .W(8)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(v_valid[0]),
    .in_ready(in_ready4), .mode(v_mode[0]), .sel(v_sel[0]),
    .out_data(out_data4), .out_ch(out_ch4), .out_valid(out_valid4),
    .out_ready(v_ordy[0])
  );

  mux_rr_select #(.N_CH(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(v_valid[1][2:0]),
    .in_ready(in_ready3), .mode(v_mode[1]), .sel(v_sel[1]),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(v_ordy[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_count = 0;
  int err_count = 0;

  // reference model state
  int n_of[2] = '{4, 3};
  int m_valid[2];
  int m_data[2];
  int m_ch[2];
  int m_ptr[2];
  int exp_rdy[2];
  int exp_ch[2];
  int exp_load[2];

  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0;
      m_data[d]  = 0;
      m_ch[d]    = 0;
      m_ptr[d]   = 0;
      exp_ch[d]  = -1;
    end
    exp_q.delete();
  endtask

  // First valid channel at or after the pointer, wrapping; -1 if none.
  function automatic int find_rr(int d);
    for (int k = 0; k < n_of[d]; k++) begin
      int c;
      c = (m_ptr[d] + k) % n_of[d];
      if (v_valid[d][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_eval(input int d);
    int load;
    int g;
    load = (m_valid[d] == 0 || v_ordy[d]) ? 1 : 0;
    exp_rdy[d] = 0;
    exp_ch[d] = -1;
    if (v_mode[d] == 1'b0) begin
      if (load == 1 && int'(v_sel[d]) < n_of[d]) begin
        exp_rdy[d] = 1 << v_sel[d];
        if (v_valid[d][v_sel[d]]) exp_ch[d] = int'(v_sel[d]);
      end
    end else begin
      g = find_rr(d);
      if (load == 1 && g >= 0) begin
        exp_rdy[d] = 1 << g;
        exp_ch[d] = g;
      end
    end
    exp_load[d] = load;
  endtask

  task automatic model_update(input int d);
    if (exp_load[d] == 1) begin
      if (exp_ch[d] >= 0) begin
        m_valid[d] = 1;
        m_data[d]  = int'(v_data[d][exp_ch[d]]);
        m_ch[d]    = exp_ch[d];
        if (v_mode[d] == 1'b1) m_ptr[d] = (exp_ch[d] + 1) % n_of[d];
      end else begin
        m_valid[d] = 0;
      end
    end
  endtask

  // driver: one clock cycle with inputs already applied after a falling edge
  task automatic cycle();
    #1;
    model_eval(0);
    model_eval(1);
    check("in_ready4", in_ready4, exp_rdy[0]);
    check("in_ready3", in_ready3, exp_rdy[1]);
    if (m_valid[0] == 1 && v_ordy[0]) begin
      if (exp_q.size() == 0) begin
        check("drain4_queue_nonempty", 0, 1);
      end else begin
        check("drain4_data", out_data4, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    model_update(0);
    model_update(1);
    if (exp_load[0] == 1 && exp_ch[0] >= 0) exp_q.push_back(v_data[0][exp_ch[0]]);
    check("out_valid4", out_valid4, m_valid[0]);
    check("out_data4", out_data4, m_data[0]);
    check("out_ch4", out_ch4, m_ch[0]);
    check("out_valid3", out_valid3, m_valid[1]);
    check("out_data3", out_data3, m_data[1]);
    check("out_ch3", out_ch3, m_ch[1]);
    @(negedge clk);
  endtask

  // producer: a channel keeps valid and data until its beat is taken
  task automatic rand_inputs(input int d);
    for (int c = 0; c < n_of[d]; c++) begin
      if (!v_valid[d][c] || exp_ch[d] == c) begin
        v_valid[d][c] = 1'($urandom_range(0, 1));
        v_data[d][c]  = 8'($urandom_range(0, 255));
      end
    end
    v_mode[d] = 1'($urandom_range(0, 1));
    v_sel[d]  = 2'($urandom_range(0, 3));
    v_ordy[d] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_all(input int d, input logic mode, input logic [1:0] sel);
    v_mode[d]  = mode;
    v_sel[d]   = sel;
    v_ordy[d]  = 1'b1;
    v_valid[d] = (d == 0) ? 4'b1111 : 4'b0111;
  endtask

  logic [7:0] hold_data;
  logic [1:0] hold_ch;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      v_valid[d] = '0;
      v_sel[d]   = '0;
      v_mode[d]  = 1'b0;
      v_ordy[d]  = 1'b0;
      for (int c = 0; c < 4; c++) v_data[d][c] = '0;
    end
    model_reset();
    #1;
    check("reset_out_valid4", out_valid4, 0);
    check("reset_out_data4", out_data4, 0);
    check("reset_out_ch4", out_ch4, 0);
    check("reset_out_valid3", out_valid3, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // fixed select, sel=2
    v_data[0][0] = 8'hA0; v_data[0][1] = 8'hB1; v_data[0][2] = 8'hC2; v_data[0][3] = 8'hD3;
    v_data[1][0] = 8'hA0; v_data[1][1] = 8'hB1; v_data[1][2] = 8'hC2;
    set_all(0, 1'b0, 2'd2);
    set_all(1, 1'b0, 2'd2);
    #1;
    check("fixed_in_ready4", in_ready4, 4'b0100);
    cycle();
    check("fixed_out_data4", out_data4, 8'hC2);
    check("fixed_out_ch4", out_ch4, 2);

    // round-robin fairness, all valid
    set_all(0, 1'b1, 2'd0);
    set_all(1, 1'b1, 2'd0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_fair_ch4", out_ch4, k % 4);
      check("rr_fair_valid4", out_valid4, 1);
      check("rr_wrap_ch3", out_ch3, k % 3);
    end

    // one more all-valid grant (ch1) leaves ptr=2; then skip/wrap over ch1/ch3
    cycle();
    check("rr_ptr2_setup", out_ch4, 1);
    v_valid[0] = 4'b1010;
    cycle();
    check("rr_skip_ch3", out_ch4, 3);
    cycle();
    check("rr_wrap_ch1", out_ch4, 1);
    cycle();
    check("rr_again_ch3", out_ch4, 3);

    // backpressure
    hold_data = out_data4;
    hold_ch   = out_ch4;
    v_ordy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_data_stable", out_data4, hold_data);
      check("bp_ch_stable", out_ch4, hold_ch);
      check("bp_in_ready", in_ready4, 0);
    end
    v_ordy[0] = 1'b1;
    cycle();
    check("bp_refill_valid", out_valid4, 1);
    check("bp_refill_ch", out_ch4, 1);

    // out-of-range select on the 3-channel instance
    set_all(1, 1'b0, 2'd3);
    #1;
    check("sel3_in_ready", in_ready3, 0);
    cycle();
    check("sel3_no_xfer", out_valid3, 0);

    // reset mid-stream
    set_all(0, 1'b1, 2'd0);
    set_all(1, 1'b1, 2'd0);
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_out_valid4", out_valid4, 0);
    check("midrst_out_data4", out_data4, 0);
    check("midrst_out_ch4", out_ch4, 0);
    check("midrst_out_valid3", out_valid3, 0);
    check("midrst_in_ready4", in_ready4, 0);
    check("midrst_in_ready3", in_ready3, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("post_rst_ptr4", out_ch4, 0);
    check("post_rst_ptr3", out_ch3, 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rand_inputs(0);
      rand_inputs(1);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", chk_count, err_count);
    $finish;
  end

endmodule

// File: doc/mux_rr_select.md
Name: mux_rr_select

Overview:
- Parametrised successor to the team's 4:1 gate-level mux: N_CH channels of W-bit data multiplexed onto one registered output.
- Channel choice is either a fixed external select or round-robin arbitration.
- Every input channel and the output use valid/ready handshakes.
- Sits between multiple producer channels and a single downstream consumer in the mux/selector datapath.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 8, data width per channel (1..64).
- SEL_W, derived as clog2(N_CH) (minimum 1), width of select and channel tag; localparam, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N_CH*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready (combinational).
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  W  registered selected data.
- out_ch  out  SEL_W  registered index of the channel that supplied out_data.
- out_valid  out  1  output register holds valid data.
- out_ready  in  1  downstream accepts when high with out_valid.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0. in_ready is all-zero while rst=1.
- load_en = !out_valid || out_ready. The single output stage refills in the same cycle it drains, giving full throughput.
- Grant is one-hot, at most one bit set, and computed combinationally.
  - Fixed mode: grant[sel]=in_valid[sel]. If sel >= N_CH (non-power-of-2 N_CH), grant=0.
  - RR mode: grant goes to the first i with in_valid[i]=1, searching ptr, ptr+1, …, wrapping modulo N_CH. No valid inputs means grant=0.
- in_ready[i] = load_en && (fixed mode ? (i==sel) : grant[i]).
  - In fixed mode ready does not depend on in_valid.
  - In RR mode ready is asserted only to the granted channel.
- Transfer on channel i: in_valid[i] && in_ready[i]. Next edge: out_data<=in_data[i], out_ch<=i, out_valid<=1.
- load_en=1 with no transfer: out_valid<=0 and out_data/out_ch hold their old values.
- load_en=0: all output registers hold. out_data and out_ch must stay stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from input transfer to out_valid.
- RR pointer:
  - Updates only on an RR-mode transfer, to (granted+1) mod N_CH, with explicit wrap for non-power-of-2 N_CH.
  - Holds in fixed mode and on idle cycles.
- Mode or sel change: sampled every cycle and affects only the current cycle's grant. No data already held in the output register is lost or reordered.
- Simultaneous output drain and input transfer in the same cycle: new data replaces old, out_valid stays 1.
- Reset asserted mid-operation: output contents are discarded immediately. No input transfer is counted while rst=1.
- Producer rule (not checked by the DUT): once in_valid[i] is high it is held until transferred.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - clog2 function, with minimum return value 1.
- Sub-module rr_arbiter:
  - Parameter N_CH.
  - Inputs: req[N_CH], ptr[SEL_W], en.
  - Outputs: one-hot gnt[N_CH] and binary gnt_idx[SEL_W].
  - Implementation: double-width rotate/priority search.
  - mux_rr_select instantiates it once and owns the ptr register.

Test Plan:
1. Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 without waiting for a clk edge; after release, ptr=0 (first RR grant with all valid goes to ch0).
2. Fixed mode, N_CH=4, W=8: in_data={8'hD3,8'hC2,8'hB1,8'hA0}, all valid, sel=2, out_ready=1 -> next cycle out_data=8'hC2, out_ch=2; in_ready=4'b0100.
3. RR fairness: all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_valid=1 every cycle after the first.
4. RR skip and wrap: only ch1 and ch3 valid, ptr=2 -> grants ch3 then ch1, then ch3 again; ptr values 0→2 path checked.
5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable, in_ready=0; out_ready=1 -> drain and refill in same cycle.
6. Non-power-of-2: N_CH=3, sel=3 in fixed mode -> in_ready=0, no transfer; RR with all valid -> out_ch 0,1,2,0 (pointer wraps at 3).
